sram_seq_ctrl: RTL and testbench



---
 rtl/sram_seq_pkg.sv | 18 +
 rtl/sram_seq_ctrl_rd_stream.sv | 63 ++++++
 rtl/sram_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_sram_seq_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the tile SRAM sequencer: FSM state encoding,
// default SRAM address widths and the input SRAM read latency.
package sram_seq_pkg;

  localparam int I_AW_DEF    = 7;
  localparam int O_AW_DEF    = 4;
  localparam int SRAM_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    DRAIN,
    WRITE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/sram_seq_ctrl_rd_stream.sv
// Consecutive-address read issuer for the input SRAM. Arm with go/base/len;
// re-arming on the last read of a burst continues without a bubble.
module sram_rd_stream
  import sram_seq_pkg::*;
#(
  parameter int AW = I_AW_DEF,
  parameter int LW = I_AW_DEF + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_go,
  input  logic [AW-1:0] i_base,
  input  logic [LW-1:0] i_len,
  input  logic          i_flush,
  output logic          o_cen,
  output logic [AW-1:0] o_addr,
  output logic          o_last,
  output logic          o_vld
);

  logic          r_active;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_rem;
  logic          r_vld_p1;
  logic          w_issue;

  assign w_issue = r_active & ~i_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_addr   <= '0;
      r_rem    <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      // stage p1: SRAM Q valid one cycle after an issued read
      r_vld_p1 <= w_issue;
      if (i_flush) begin
        r_active <= 1'b0;
        r_addr   <= '0;
        r_rem    <= '0;
      end else if (i_go) begin
        r_active <= 1'b1;
        r_addr   <= i_base;
        r_rem    <= i_len - 1'b1;
      end else if (r_active) begin
        if (r_rem == '0) begin
          r_active <= 1'b0;
          r_addr   <= '0;
        end else begin
          r_addr <= r_addr + 1'b1;
          r_rem  <= r_rem - 1'b1;
        end
      end
    end
  end

  assign o_cen  = ~w_issue;
  assign o_addr = r_addr;
  assign o_last = w_issue && (r_rem == '0);
  assign o_vld  = r_vld_p1;

endmodule

// File: rtl/sram_seq_ctrl.sv
// Tile sequencer: weights then activations from the input SRAM into L0, drain,
// then OFIFO rows into the output SRAM. Define SEQ_ABORT_EN to add the abort input.
module sram_seq_ctrl
  import sram_seq_pkg::*;
#(
  parameter int I_AW      = I_AW_DEF,
  parameter int O_AW      = O_AW_DEF,
  parameter int W_BASE    = 0,
  parameter int W_LEN     = 8,
  parameter int X_LEN     = 36,
  parameter int DRAIN_CYC = 12,
  parameter int O_LEN     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef SEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic [I_AW-1:0] I_A,
  output logic            I_CEN,
  output logic            I_WEN,
  output logic            l0_wr,
  output logic            load_w,
  output logic            execute,
  input  logic            ofifo_valid,
  output logic            ofifo_rd,
  output logic [O_AW-1:0] O_A,
  output logic            O_CEN,
  output logic            O_WEN
);

  localparam int LW      = I_AW + 1;
  localparam int OC_W    = O_AW + 1;
  localparam int DC_W    = $clog2(DRAIN_CYC + 1) + 1;
  localparam int DC_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

  if (W_BASE + W_LEN + X_LEN > (1 << I_AW) || W_LEN < 1 || X_LEN < 1 ||
      O_LEN < 1 || O_LEN > (1 << O_AW) || DRAIN_CYC < 0 || SRAM_RD_LAT != 1) begin : g_bad_cfg
    $error("sram_seq_ctrl: illegal parameter combination");
  end

  seq_state_t      r_state, w_next;
  logic            r_busy, r_done;
  logic            r_load_w_p1, r_execute_p1, r_wr_pend_p1;
  logic [OC_W-1:0] r_issued, r_widx;
  logic [DC_W-1:0] r_dcnt;
  logic            w_go, w_flush, w_wr, w_ofifo_rd;
  logic [I_AW-1:0] w_base, w_rd_addr;
  logic [LW-1:0]   w_len;
  logic            w_rd_cen, w_rd_last, w_rd_vld, w_rd_issue;

`ifdef SEQ_ABORT_EN
  assign w_flush = abort && (r_state != IDLE);
`else
  assign w_flush = 1'b0;
`endif

  sram_rd_stream #(.AW(I_AW), .LW(LW)) u_rd_stream (
    .clk     (clk),
    .reset   (reset),
    .i_go    (w_go),
    .i_base  (w_base),
    .i_len   (w_len),
    .i_flush (w_flush),
    .o_cen   (w_rd_cen),
    .o_addr  (w_rd_addr),
    .o_last  (w_rd_last),
    .o_vld   (w_rd_vld)
  );

  assign w_rd_issue = ~w_rd_cen;
  assign w_wr       = r_wr_pend_p1 & ~w_flush;
  assign w_ofifo_rd = (r_state == WRITE) && ofifo_valid &&
                      (r_issued < OC_W'(O_LEN)) && !w_flush;

  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    w_base = I_AW'(W_BASE);
    w_len  = LW'(W_LEN);
    case (r_state)
      IDLE:   if (start) begin
                w_next = LOAD_W;
                w_go   = 1'b1;
              end
      // re-arm on the last weight read so activations follow with no gap
      LOAD_W: if (w_rd_last) begin
                w_next = LOAD_X;
                w_go   = 1'b1;
                w_base = I_AW'(W_BASE + W_LEN);
                w_len  = LW'(X_LEN);
              end
      LOAD_X: if (w_rd_last) w_next = DRAIN;
      DRAIN:  if (r_dcnt == DC_W'(DC_LAST)) w_next = WRITE;
      WRITE:  if (w_wr && (r_widx == OC_W'(O_LEN - 1))) w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_flush) begin
      w_next = IDLE;
      w_go   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_w_p1  <= 1'b0;
      r_execute_p1 <= 1'b0;
      r_wr_pend_p1 <= 1'b0;
      r_issued     <= '0;
      r_widx       <= '0;
      r_dcnt       <= '0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != IDLE);
      r_done       <= (w_next == DONE);
      // stage p1: qualifiers and output write trail their issue by one cycle
      r_load_w_p1  <= w_rd_issue && (r_state == LOAD_W);
      r_execute_p1 <= w_rd_issue && (r_state == LOAD_X);
      r_wr_pend_p1 <= w_ofifo_rd;
      r_dcnt       <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
      if (r_state != WRITE) r_issued <= '0;
      else if (w_ofifo_rd)  r_issued <= r_issued + 1'b1;
      if (r_state != WRITE) r_widx <= '0;
      else if (w_wr)        r_widx <= r_widx + 1'b1;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign I_A      = w_rd_addr;
  assign I_CEN    = w_rd_cen;
  assign I_WEN    = 1'b1;
  assign l0_wr    = w_rd_vld;
  assign load_w   = r_load_w_p1;
  assign execute  = r_execute_p1;
  assign ofifo_rd = w_ofifo_rd;
  assign O_A      = w_wr ? r_widx[O_AW-1:0] : '0;
  assign O_CEN    = ~w_wr;
  assign O_WEN    = ~w_wr;

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Self-checking bench for sram_seq_ctrl: per-cycle comparison of every output
// against a tile-timeline reference model; abort scenario under SEQ_ABORT_EN.
module tb_sram_seq_ctrl;

  localparam int I_AW      = 7;
  localparam int O_AW      = 4;
  localparam int W_BASE    = 0;
  localparam int W_LEN     = 8;
  localparam int X_LEN     = 36;
  localparam int DRAIN_CYC = 12;
  localparam int O_LEN     = 16;
  localparam int WS        = 1 + W_LEN + X_LEN + ((DRAIN_CYC > 0) ? DRAIN_CYC : 1);
  localparam int LIMIT     = 2000;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic [I_AW-1:0] ia;
    logic            icen;
    logic            iwen;
    logic            l0_wr;
    logic            load_w;
    logic            execute;
    logic            ofifo_rd;
    logic [O_AW-1:0] oa;
    logic            ocen;
    logic            owen;
  } obs_t;

  logic            clk = 1'b0;
  logic            reset, start, ofifo_valid;
`ifdef SEQ_ABORT_EN
  logic            abort;
`endif
  logic            busy, done, I_CEN, I_WEN, l0_wr, load_w, execute, ofifo_rd, O_CEN, O_WEN;
  logic [I_AW-1:0] I_A;
  logic [O_AW-1:0] O_A;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state for the write phase of the current tile
  int m_issued, m_written, m_phase;
  bit m_prev_rd;

  sram_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef SEQ_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .I_A         (I_A),
    .I_CEN       (I_CEN),
    .I_WEN       (I_WEN),
    .l0_wr       (l0_wr),
    .load_w      (load_w),
    .execute     (execute),
    .ofifo_valid (ofifo_valid),
    .ofifo_rd    (ofifo_rd),
    .O_A         (O_A),
    .O_CEN       (O_CEN),
    .O_WEN       (O_WEN)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    return {busy, done, I_A, I_CEN, I_WEN, l0_wr, load_w, execute, ofifo_rd, O_A, O_CEN, O_WEN};
  endfunction

  function automatic obs_t idle_obs();
    obs_t e;
    e      = '0;
    e.icen = 1'b1;
    e.iwen = 1'b1;
    e.ocen = 1'b1;
    e.owen = 1'b1;
    return e;
  endfunction

  task automatic model_init();
    m_issued  = 0;
    m_written = 0;
    m_phase   = 0;
    m_prev_rd = 1'b0;
  endtask

  // k = cycles since the start-accepting IDLE cycle (k=0)
  task automatic model_cycle(input int k, input logic v, input logic a, output obs_t e);
    bit rd;
    e = idle_obs();
    if (k == 0 || m_phase == 2) return;
    e.busy = 1'b1;
    if (m_phase == 1) begin
      e.done  = 1'b1;
      m_phase = 2;
      return;
    end
    if (k >= 1 && k <= W_LEN + X_LEN) begin
      e.icen = 1'b0;
      e.ia   = I_AW'(W_BASE + k - 1);
    end
    e.l0_wr   = (k >= 2 && k <= W_LEN + X_LEN + 1);
    e.load_w  = (k >= 2 && k <= W_LEN + 1);
    e.execute = (k >= W_LEN + 2 && k <= W_LEN + X_LEN + 1);
    if (a) begin
      e.icen    = 1'b1;
      m_prev_rd = 1'b0;
      m_phase   = 2;
      return;
    end
    if (k >= WS) begin
      rd = v && (m_issued < O_LEN);
      if (m_prev_rd) begin
        e.ocen = 1'b0;
        e.owen = 1'b0;
        e.oa   = O_AW'(m_written);
        m_written++;
        if (m_written == O_LEN) m_phase = 1;
      end
      e.ofifo_rd = rd;
      m_prev_rd  = rd;
      if (rd) m_issued++;
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic a);
    @(posedge clk);
    #1;
    start       = s;
    ofifo_valid = v;
`ifdef SEQ_ABORT_EN
    abort       = a;
`else
    if (a) start = s;
`endif
  endtask

  task automatic test_reset();
    obs_t e, got;
    e = idle_obs();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    got = sample();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_hold got=%h want=%h", got, e);
    end
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    got = sample();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=%h", got, e);
    end
  endtask

  task automatic test_nominal();
    obs_t e, got;
    model_init();
    for (int k = 0; k <= WS + O_LEN + 3; k++) begin
      drive(k == 0, 1'b1, 1'b0);
      model_cycle(k, 1'b1, 1'b0, e);
      @(negedge clk);
      got = sample();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL nominal k=%0d got=%h want=%h", k, got, e);
      end
    end
  endtask

  // mode 0: ofifo_valid toggles 1,0,1,.. ; mode 1: random valid and stray starts
  task automatic test_valid_pattern(input string nm, input int mode);
    obs_t e, got;
    logic v, s;
    int   tail;
    tail = -1;
    model_init();
    for (int k = 0; k < LIMIT; k++) begin
      v = (mode == 0) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
      s = (k == 0) || (k == 20) ||
          (mode == 1 && k >= 1 && k < WS && $urandom_range(0, 7) == 0);
      drive(s, v, 1'b0);
      model_cycle(k, v, 1'b0, e);
      @(negedge clk);
      got = sample();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s k=%0d got=%h want=%h", nm, k, got, e);
      end
      if (e.done) tail = k + 2;
      if (k == tail) break;
    end
    n_tests++;
    if (tail < 0) begin
      n_fail++;
      $display("FAIL %s_timeout done_seen=0 want=1", nm);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, got;
    bit   seen;
    for (int t = 0; t < 2; t++) begin
      model_init();
      seen = 1'b0;
      for (int k = 0; k < LIMIT && !seen; k++) begin
        drive((t == 0) ? 1'b1 : (k == 0), 1'b1, 1'b0);
        model_cycle(k, 1'b1, 1'b0, e);
        @(negedge clk);
        got = sample();
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL b2b t=%0d k=%0d got=%h want=%h", t, k, got, e);
        end
        if (e.done) seen = 1'b1;
      end
      n_tests++;
      if (!seen) begin
        n_fail++;
        $display("FAIL b2b_timeout t=%0d done_seen=0 want=1", t);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0);
      model_cycle(LIMIT, 1'b1, 1'b0, e);
      @(negedge clk);
      got = sample();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL b2b_idle k=%0d got=%h want=%h", k, got, e);
      end
    end
  endtask

  task automatic test_reset_mid(input int rk);
    obs_t e, got;
    model_init();
    for (int k = 0; k < rk; k++) begin
      drive(k == 0, 1'b1, 1'b0);
      model_cycle(k, 1'b1, 1'b0, e);
      @(negedge clk);
      got = sample();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rst_pre rk=%0d k=%0d got=%h want=%h", rk, k, got, e);
      end
    end
    e = idle_obs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    got = sample();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL rst_async rk=%0d got=%h want=%h", rk, got, e);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    got = sample();
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL rst_after rk=%0d got=%h want=%h", rk, got, e);
    end
    model_init();
    for (int k = 0; k <= WS + O_LEN + 2; k++) begin
      drive(k == 0, 1'b1, 1'b0);
      model_cycle(k, 1'b1, 1'b0, e);
      @(negedge clk);
      got = sample();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rst_restart rk=%0d k=%0d got=%h want=%h", rk, k, got, e);
      end
    end
  endtask

`ifdef SEQ_ABORT_EN
  task automatic test_abort();
    obs_t e, got;
    logic a;
    bit   seen;
    model_init();
    for (int k = 0; k <= 63; k++) begin
      a = (k == 60) || (k == 62);
      drive(k == 0, 1'b1, a);
      model_cycle(k, 1'b1, a, e);
      @(negedge clk);
      got = sample();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL abort k=%0d got=%h want=%h", k, got, e);
      end
    end
    model_init();
    seen = 1'b0;
    for (int k = 0; k < LIMIT && !seen; k++) begin
      a = (k == 0);
      drive(k == 0, 1'b1, a);
      model_cycle(k, 1'b1, 1'b0, e);
      @(negedge clk);
      got = sample();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL abort_next k=%0d got=%h want=%h", k, got, e);
      end
      if (e.done) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_next_timeout done_seen=0 want=1");
    end
  endtask
`endif

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    ofifo_valid = 1'b0;
`ifdef SEQ_ABORT_EN
    abort       = 1'b0;
`endif
    test_reset();
    test_nominal();
    test_valid_pattern("toggle", 0);
    test_valid_pattern("random", 1);
    test_valid_pattern("random2", 1);
    test_back_to_back();
    test_reset_mid(20);
    test_reset_mid(WS + 3);
`ifdef SEQ_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
